dmem_arbiter: RTL and testbench

//  Shares the single-port data memory between the CPU load/store path and a debug/loader port.

---
 rtl/dmem_arbiter.sv | 145 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU load/store path and the debug/loader port.
// Round-robin on ties, with a bounded debug burst lock followed by one forced CPU slot.
module dmem_arbiter #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_LOCK = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_gnt_o,
  output logic              cpu_stall_o,
  output logic              cpu_rvalid_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  input  logic              dbg_lock_i,
  output logic              dbg_gnt_o,
  output logic              dbg_rvalid_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wd_o,
  input  logic [DATA_W-1:0] mem_rd_i
);

  localparam int unsigned        CNT_W   = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(MAX_LOCK);

  typedef enum logic [1:0] {
    ST_ARB       = 2'd0,
    ST_DBG_LOCK  = 2'd1,
    ST_CPU_FORCE = 2'd2
  } st_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } own_e;

  st_e              st_q, st_d;
  own_e             owner_q, owner_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             cpu_gnt, dbg_gnt;
  logic             cpu_rvalid_q;
  logic             dbg_rvalid_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dbg_rdata_q;

  // Grant decision and next state; grants are forced low while reset is held
  always_comb begin
    st_d       = st_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    cpu_gnt    = 1'b0;
    dbg_gnt    = 1'b0;
    case (st_q)
      ST_ARB: begin
        if (cpu_req_i && dbg_req_i) begin
          cpu_gnt = (owner_q == OWN_DBG);
          dbg_gnt = (owner_q == OWN_CPU);
        end else begin
          cpu_gnt = cpu_req_i;
          dbg_gnt = dbg_req_i;
        end
        if (cpu_gnt) owner_d = OWN_CPU;
        if (dbg_gnt) begin
          owner_d = OWN_DBG;
          if (dbg_lock_i) begin
            lock_cnt_d = CNT_W'(1);
            st_d       = (MAX_LOCK <= 1) ? ST_CPU_FORCE : ST_DBG_LOCK;
          end
        end
      end
      ST_DBG_LOCK: begin
        dbg_gnt = dbg_req_i;
        if (dbg_gnt) lock_cnt_d = lock_cnt_q + CNT_W'(1);
        // The grant that fills the budget hands the next slot to the CPU
        if (dbg_gnt && (lock_cnt_d >= CNT_MAX)) st_d = ST_CPU_FORCE;
        else if (!dbg_lock_i)                    st_d = ST_ARB;
      end
      ST_CPU_FORCE: begin
        cpu_gnt    = cpu_req_i;
        owner_d    = OWN_CPU;
        lock_cnt_d = '0;
        st_d       = ST_ARB;
      end
      default: st_d = ST_ARB;
    endcase
    if (reset) begin
      cpu_gnt = 1'b0;
      dbg_gnt = 1'b0;
    end
  end

  // Memory port follows the granted requester, idle-zero otherwise
  always_comb begin
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_wd_o   = '0;
    if (cpu_gnt) begin
      mem_we_o   = cpu_we_i;
      mem_addr_o = cpu_addr_i;
      mem_wd_o   = cpu_wdata_i;
    end else if (dbg_gnt) begin
      mem_we_o   = dbg_we_i;
      mem_addr_o = dbg_addr_i;
      mem_wd_o   = dbg_wdata_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q         <= ST_ARB;
      owner_q      <= OWN_DBG;
      lock_cnt_q   <= '0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      st_q         <= st_d;
      owner_q      <= owner_d;
      lock_cnt_q   <= lock_cnt_d;
      cpu_rvalid_q <= cpu_gnt && !cpu_we_i;
      dbg_rvalid_q <= dbg_gnt && !dbg_we_i;
      if (cpu_gnt && !cpu_we_i) cpu_rdata_q <= mem_rd_i;
      if (dbg_gnt && !dbg_we_i) dbg_rdata_q <= mem_rd_i;
    end
  end

  assign cpu_gnt_o    = cpu_gnt;
  assign dbg_gnt_o    = dbg_gnt;
  assign cpu_stall_o  = cpu_req_i && !cpu_gnt;
  assign cpu_rvalid_o = cpu_rvalid_q;
  assign dbg_rvalid_o = dbg_rvalid_q;
  assign cpu_rdata_o  = cpu_rdata_q;
  assign dbg_rdata_o  = dbg_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then constrained-random traffic, checked against
// a cycle-level behavioural model of the arbitration rules and a shadow copy of memory.
module tb_dmem_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned ML = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd, mem_rd;

  logic          mem_clr;
  logic [DW-1:0] mem [256];

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  bit            m_last_dbg;
  int            m_burst;
  bit            m_force;
  logic [DW-1:0] shadow [256];
  logic          e_crv, e_drv;
  logic [DW-1:0] e_crd, e_drd;
  bit            g_c, g_d;
  bit            o_c, o_d, o_stall;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
    .clk(clk), .reset(reset),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_gnt_o(cpu_gnt), .cpu_stall_o(cpu_stall), .cpu_rvalid_o(cpu_rvalid), .cpu_rdata_o(cpu_rdata),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .dbg_lock_i(dbg_lock), .dbg_gnt_o(dbg_gnt), .dbg_rvalid_o(dbg_rvalid), .dbg_rdata_o(dbg_rdata),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wd_o(mem_wd), .mem_rd_i(mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wd;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_last_dbg = 1'b1;
    m_burst    = 0;
    m_force    = 1'b0;
    e_crv      = 1'b0;
    e_drv      = 1'b0;
    e_crd      = '0;
    e_drd      = '0;
  endtask

  task automatic drive(input bit cr, input bit cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                       input bit dr, input bit dw, input logic [AW-1:0] da, input logic [DW-1:0] dd,
                       input bit dl);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd; dbg_lock = dl;
  endtask

  // One clock cycle: predict and check grants/mux, clock, then check read returns
  task automatic cycle();
    logic          e_we;
    logic [AW-1:0] e_addr;
    if (m_force) begin
      g_c = cpu_req; g_d = 1'b0;
    end else if (m_burst > 0) begin
      g_c = 1'b0; g_d = dbg_req;
    end else if (cpu_req && dbg_req) begin
      g_c = m_last_dbg; g_d = !m_last_dbg;
    end else begin
      g_c = cpu_req; g_d = dbg_req;
    end
    e_we   = g_c ? cpu_we   : (g_d ? dbg_we   : 1'b0);
    e_addr = g_c ? cpu_addr : (g_d ? dbg_addr : '0);
    #1;
    o_c = cpu_gnt; o_d = dbg_gnt; o_stall = cpu_stall;
    chk("cpu_gnt", 64'(cpu_gnt), 64'(g_c));
    chk("dbg_gnt", 64'(dbg_gnt), 64'(g_d));
    chk("cpu_stall", 64'(cpu_stall), 64'(cpu_req && !g_c));
    chk("mem_we", 64'(mem_we), 64'(e_we));
    chk("mem_addr", 64'(mem_addr), 64'(e_addr));
    @(posedge clk);
    #1;
    e_crv = g_c && !cpu_we;
    e_drv = g_d && !dbg_we;
    if (e_crv) e_crd = shadow[cpu_addr];
    if (e_drv) e_drd = shadow[dbg_addr];
    if (g_c && cpu_we) shadow[cpu_addr] = cpu_wdata;
    if (g_d && dbg_we) shadow[dbg_addr] = dbg_wdata;
    if (m_force) begin
      m_force    = 1'b0;
      m_last_dbg = 1'b0;
    end else if (m_burst > 0) begin
      if (g_d) m_burst++;
      if (g_d && m_burst >= ML) begin
        m_burst = 0;
        m_force = 1'b1;
      end else if (!dbg_lock) begin
        m_burst = 0;
      end
    end else begin
      if (g_c) m_last_dbg = 1'b0;
      if (g_d) begin
        m_last_dbg = 1'b1;
        if (dbg_lock) begin
          if (ML == 1) m_force = 1'b1;
          else         m_burst = 1;
        end
      end
    end
    chk("cpu_rvalid", 64'(cpu_rvalid), 64'(e_crv));
    chk("dbg_rvalid", 64'(dbg_rvalid), 64'(e_drv));
    chk("cpu_rdata", 64'(cpu_rdata), 64'(e_crd));
    chk("dbg_rdata", 64'(dbg_rdata), 64'(e_drd));
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int            cnt;
    logic [3:0]    seq;
    bit            cr, cw, dr, dw, dl;
    logic [AW-1:0] ca, da;
    logic [DW-1:0] cd, dd;

    for (int i = 0; i < 256; i++) shadow[i] = '0;
    model_reset();
    reset   = 1'b1;
    mem_clr = 1'b1;
    drive(1'b1, 1'b1, 8'h05, 32'h1, 1'b1, 1'b1, 8'h06, 32'h2, 1'b1);
    #12;
    chk("rst_cpu_gnt", 64'(cpu_gnt), 64'(0));
    chk("rst_dbg_gnt", 64'(dbg_gnt), 64'(0));
    chk("rst_mem_we", 64'(mem_we), 64'(0));
    chk("rst_cpu_rvalid", 64'(cpu_rvalid), 64'(0));
    chk("rst_dbg_rvalid", 64'(dbg_rvalid), 64'(0));
    chk("rst_cpu_rdata", 64'(cpu_rdata), 64'(0));
    chk("rst_dbg_rdata", 64'(dbg_rdata), 64'(0));
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    mem_clr = 1'b0;

    // CPU-only store then load
    drive(1'b1, 1'b1, 8'h05, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0, 1'b0);
    cycle();
    drive(1'b1, 1'b0, 8'h05, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    cycle();
    chk("cpu_load_data", 64'(cpu_rdata), 64'(32'hDEADBEEF));
    chk("cpu_load_stall", 64'(o_stall), 64'(0));

    // Tie after reset alternates starting with the CPU
    pulse_reset();
    drive(1'b1, 1'b0, 8'h05, '0, 1'b1, 1'b0, 8'h05, '0, 1'b0);
    seq = '0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      seq = {seq[2:0], o_c};
    end
    chk("tie_sequence", 64'(seq), 64'(4'b1010));

    // Debug burst lock capped at ML grants
    drive(1'b1, 1'b0, 8'h00, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    cycle();
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 8'h10, '0, 1'b1, 1'b1, 8'(8'h10 + i), 32'(32'hA000_0000 + i), 1'b1);
      cycle();
      if (o_d && o_stall) cnt++;
    end
    chk("burst_dbg_grants", 64'(cnt), 64'(16));
    drive(1'b1, 1'b0, 8'h1F, '0, 1'b1, 1'b1, 8'h2F, 32'h5, 1'b1);
    cycle();
    chk("burst_cpu_17th", 64'(o_c), 64'(1));
    chk("burst_cpu_data", 64'(cpu_rdata), 64'(32'hA000_000F));

    // Early unlock: lock dropped with the third write
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 8'h11, '0, 1'b1, 1'b1, 8'(8'h40 + i), 32'(32'hB0 + i), (i < 2));
      cycle();
    end
    drive(1'b1, 1'b0, 8'h11, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    cycle();
    chk("unlock_cpu_gnt", 64'(o_c), 64'(1));

    // Cross-port read-after-write
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 8'h20, 32'h12345678, 1'b0);
    cycle();
    drive(1'b1, 1'b0, 8'h20, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    cycle();
    chk("raw_cpu_data", 64'(cpu_rdata), 64'(32'h12345678));
    chk("raw_dbg_rvalid", 64'(dbg_rvalid), 64'(0));

    // Reset during a locked debug read drops the pending pulse
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'h11, '0, 1'b1);
    cycle();
    drive(1'b1, 1'b0, 8'h03, '0, 1'b1, 1'b0, 8'h11, '0, 1'b1);
    reset = 1'b1;
    #1;
    chk("midrst_dbg_rvalid", 64'(dbg_rvalid), 64'(0));
    chk("midrst_cpu_gnt", 64'(cpu_gnt), 64'(0));
    chk("midrst_dbg_gnt", 64'(dbg_gnt), 64'(0));
    chk("midrst_mem_we", 64'(mem_we), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    drive(1'b1, 1'b0, 8'h03, '0, 1'b1, 1'b0, 8'h04, '0, 1'b0);
    cycle();
    chk("postrst_tie_cpu", 64'(o_c), 64'(1));

    // Random traffic; a waiting requester keeps its signals until granted
    cr = 1'b0; cw = 1'b0; ca = '0; cd = '0;
    dr = 1'b0; dw = 1'b0; da = '0; dd = '0; dl = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!(cr && !g_c)) begin
        cr = ($urandom_range(0, 3) != 0);
        cw = ($urandom_range(0, 1) != 0);
        ca = 8'($urandom_range(0, 15));
        cd = $urandom;
      end
      if (!(dr && !g_d)) begin
        dr = ($urandom_range(0, 2) != 0);
        dw = ($urandom_range(0, 1) != 0);
        da = 8'($urandom_range(0, 15));
        dd = $urandom;
        dl = ($urandom_range(0, 7) != 0);
      end
      drive(cr, cw, ca, cd, dr, dw, da, dd, dl);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
